// File: rtl/core_pkg.sv
// Shared definitions for the core sequencer: FSM state encoding and default
// datapath/PC parameters.
package core_pkg;

    localparam int          XLEN_DEF     = 32;
    localparam int          PC_STEP_DEF  = 4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_OPERAND   = 3'd3,
        ST_EXECUTE   = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALT      = 3'd6
    } state_t;

endpackage

// File: rtl/operand_handshake.sv
// Read/valid tracking for one source operand: latches "used" at decode and
// holds the read request until the operand has been seen valid.
module operand_handshake (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic used_i,
    input  logic active_i,
    input  logic valid_i,
    output logic read_o,
    output logic done_o
);

    logic used_q;
    logic got_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            used_q <= 1'b0;
            got_q  <= 1'b0;
        end else if (load_i) begin
            used_q <= used_i;
            got_q  <= 1'b0;
        end else if (active_i && used_q && valid_i) begin
            got_q <= 1'b1;
        end
    end

    assign read_o = active_i && used_q && !got_q;
    // A valid arriving this cycle already counts, so EXECUTE follows directly.
    assign done_o = !used_q || got_q || valid_i;

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/operand/execute/writeback sequencer owning the PC.
// Optional single-step mode via `define SEQ_STEP_EN (adds step_req input).
//
// state     | meaning
// IDLE      | waiting for run (or step_req in step mode)
// FETCH     | imem_req held until imem_ack, instruction latched
// DECODE    | one-cycle dec_en, decoder flags captured
// OPERAND   | rs1/rs2 read requests until all used operands valid
// EXECUTE   | one-cycle exec_en, jump request captured
// WRITEBACK | rd_we/retire pulse, PC update
// HALT      | misaligned jump target; terminal until rst
module core_sequencer
    import core_pkg::*;
#(
    parameter int             XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
    parameter int             PC_STEP  = PC_STEP_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
`ifdef SEQ_STEP_EN
    input  logic            step_req,
`endif
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    output logic            dec_en,
    input  logic            dec_rs1_used,
    input  logic            dec_rs2_used,
    input  logic            dec_rd_write,
    output logic            rs1_read,
    output logic            rs2_read,
    input  logic            rs1_valid,
    input  logic            rs2_valid,
    output logic            exec_en,
    output logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] next_pc,
    input  logic            pc_j_valid,
    output logic            rd_we,
    output logic            retire,
    output logic            fault,
    output logic [2:0]      state
);

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic              fault_q, fault_d;
    logic              rd_write_q, rd_write_d;
    logic              j_valid_q, j_valid_d;
    logic [XLEN-1:0]   j_target_q, j_target_d;
    logic              rs1_done, rs2_done;
    logic              go;

`ifdef SEQ_STEP_EN
    assign go = step_req;
`else
    assign go = run;
`endif

    operand_handshake u_rs1 (
        .clk_i    (clk),
        .rst_i    (rst),
        .load_i   (state_q == ST_DECODE),
        .used_i   (dec_rs1_used),
        .active_i (state_q == ST_OPERAND),
        .valid_i  (rs1_valid),
        .read_o   (rs1_read),
        .done_o   (rs1_done)
    );

    operand_handshake u_rs2 (
        .clk_i    (clk),
        .rst_i    (rst),
        .load_i   (state_q == ST_DECODE),
        .used_i   (dec_rs2_used),
        .active_i (state_q == ST_OPERAND),
        .valid_i  (rs2_valid),
        .read_o   (rs2_read),
        .done_o   (rs2_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            fault_q    <= 1'b0;
            rd_write_q <= 1'b0;
            j_valid_q  <= 1'b0;
            j_target_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            fault_q    <= fault_d;
            rd_write_q <= rd_write_d;
            j_valid_q  <= j_valid_d;
            j_target_q <= j_target_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        fault_d    = fault_q;
        rd_write_d = rd_write_q;
        j_valid_d  = j_valid_q;
        j_target_d = j_target_q;
        case (state_q)
            ST_IDLE: begin
                if (go) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                rd_write_d = dec_rd_write;
                state_d    = (dec_rs1_used || dec_rs2_used) ? ST_OPERAND : ST_EXECUTE;
            end
            ST_OPERAND: begin
                if (rs1_done && rs2_done) state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                j_valid_d  = pc_j_valid;
                j_target_d = next_pc;
                if (pc_j_valid && (next_pc[1:0] != 2'b00)) begin
                    fault_d = 1'b1;
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_WRITEBACK: begin
                pc_d = j_valid_q ? j_target_q : pc_q + XLEN'(PC_STEP);
`ifdef SEQ_STEP_EN
                state_d = ST_IDLE;
`else
                state_d = run ? ST_FETCH : ST_IDLE;
`endif
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign imem_req  = (state_q == ST_FETCH);
    assign imem_addr = pc_q;
    assign instr     = instr_q;
    assign dec_en    = (state_q == ST_DECODE);
    assign exec_en   = (state_q == ST_EXECUTE);
    assign rd_we     = (state_q == ST_WRITEBACK) && rd_write_q;
    assign retire    = (state_q == ST_WRITEBACK);
    assign pc        = pc_q;
    assign fault     = fault_q;
    assign state     = state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized bench for core_sequencer: the bench plays memory, decoder, register
// file and control_unit, and predicts each instruction's phases, PC and strobes.
module tb_core_sequencer;

    logic        clk = 1'b0;
    logic        rst, run, step_req;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata, instr;
    logic        dec_en, dec_rs1_used, dec_rs2_used, dec_rd_write;
    logic        rs1_read, rs2_read, rs1_valid, rs2_valid;
    logic        exec_en, pc_j_valid, rd_we, retire, fault;
    logic [31:0] pc, next_pc;
    logic [2:0]  state;

`ifdef SEQ_STEP_EN
    localparam bit STEP = 1'b1;
`else
    localparam bit STEP = 1'b0;
`endif

    core_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
`ifdef SEQ_STEP_EN
        .step_req     (step_req),
`endif
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .dec_en       (dec_en),
        .dec_rs1_used (dec_rs1_used),
        .dec_rs2_used (dec_rs2_used),
        .dec_rd_write (dec_rd_write),
        .rs1_read     (rs1_read),
        .rs2_read     (rs2_read),
        .rs1_valid    (rs1_valid),
        .rs2_valid    (rs2_valid),
        .exec_en      (exec_en),
        .pc           (pc),
        .next_pc      (next_pc),
        .pc_j_valid   (pc_j_valid),
        .rd_we        (rd_we),
        .retire       (retire),
        .fault        (fault),
        .state        (state)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          retire_seen = 0;
    int          exp_retires = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    bit          exp_idle;

    always @(negedge clk) if (retire === 1'b1 && rst === 1'b0) retire_seen++;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_pc    = 32'h0;
        exp_instr = 32'h0;
        exp_idle  = 1'b1;
    endtask

    // From IDLE: one cycle that must not start (run low, or step_req low in step mode),
    // then one start cycle. imem_ack noise in IDLE must not touch instr.
    task automatic enter_fetch();
        run        = STEP;
        step_req   = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = $urandom;
        check_eq("idle_hold_state", 32'(state), 32'd0);
        check_eq("idle_instr", instr, exp_instr);
        tick();
        check_eq("idle_still", 32'(state), 32'd0);
        run      = STEP ? 1'($urandom % 2) : 1'b1;
        step_req = 1'b1;
        imem_ack = 1'b0;
        tick();
        step_req = 1'b0;
        exp_idle = 1'b0;
    endtask

    task automatic do_instr(input bit u1, input bit u2, input bit rdw, input bit jmp,
                            input logic [31:0] tgt, input int ack_dly, input int d1,
                            input int d2, input bit run_after);
        logic [31:0] w;
        int          last;
        bit          nxt_fetch;
        if (exp_idle) enter_fetch();
        w = $urandom;
        for (int k = 0; k <= ack_dly; k++) begin
            imem_ack   = (k == ack_dly);
            imem_rdata = (k == ack_dly) ? w : $urandom;
            check_eq("fetch_state", 32'(state), 32'd1);
            check_eq("imem_req", 32'(imem_req), 32'd1);
            check_eq("imem_addr", imem_addr, exp_pc);
            check_eq("fetch_no_retire", 32'(retire), 32'd0);
            tick();
        end
        imem_ack     = 1'($urandom % 2);
        imem_rdata   = $urandom;
        dec_rs1_used = u1;
        dec_rs2_used = u2;
        dec_rd_write = rdw;
        exp_instr    = w;
        check_eq("decode_state", 32'(state), 32'd2);
        check_eq("dec_en", 32'(dec_en), 32'd1);
        check_eq("instr", instr, w);
        tick();
        imem_ack     = 1'b0;
        dec_rs1_used = 1'($urandom % 2);
        dec_rs2_used = 1'($urandom % 2);
        dec_rd_write = 1'($urandom % 2);
        if (u1 || u2) begin
            last = 0;
            if (u1 && d1 > last) last = d1;
            if (u2 && d2 > last) last = d2;
            for (int c = 0; c <= last; c++) begin
                rs1_valid = u1 ? (c == d1) : 1'($urandom % 2);
                rs2_valid = u2 ? (c == d2) : 1'($urandom % 2);
                check_eq("operand_state", 32'(state), 32'd3);
                check_eq("rs1_read", 32'(rs1_read), 32'(u1 && c <= d1));
                check_eq("rs2_read", 32'(rs2_read), 32'(u2 && c <= d2));
                check_eq("operand_no_exec", 32'(exec_en), 32'd0);
                tick();
            end
        end
        rs1_valid  = 1'b0;
        rs2_valid  = 1'b0;
        pc_j_valid = jmp;
        next_pc    = tgt;
        check_eq("execute_state", 32'(state), 32'd4);
        check_eq("exec_en", 32'(exec_en), 32'd1);
        check_eq("exec_rs_read", 32'({rs1_read, rs2_read}), 32'd0);
        tick();
        pc_j_valid = 1'($urandom % 2);
        next_pc    = $urandom;
        if (jmp && tgt[1:0] != 2'b00) begin
            check_eq("halt_state", 32'(state), 32'd6);
            check_eq("halt_fault", 32'(fault), 32'd1);
            check_eq("halt_no_retire", 32'(retire), 32'd0);
            check_eq("halt_pc", pc, exp_pc);
            return;
        end
        run = run_after;
        check_eq("wb_state", 32'(state), 32'd5);
        check_eq("wb_retire", 32'(retire), 32'd1);
        check_eq("wb_rd_we", 32'(rd_we), 32'(rdw));
        check_eq("wb_pc_old", pc, exp_pc);
        tick();
        exp_retires++;
        exp_pc    = jmp ? tgt : exp_pc + 32'd4;
        nxt_fetch = !STEP && run_after;
        check_eq("pc_update", pc, exp_pc);
        check_eq("post_wb_state", 32'(state), nxt_fetch ? 32'd1 : 32'd0);
        check_eq("post_wb_no_retire", 32'(retire), 32'd0);
        exp_idle = !nxt_fetch;
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; step_req = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0;
        dec_rs1_used = 1'b0; dec_rs2_used = 1'b0; dec_rd_write = 1'b0;
        rs1_valid = 1'b0; rs2_valid = 1'b0; pc_j_valid = 1'b0; next_pc = '0;
        do_reset();
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_pc", pc, 32'h0);
        check_eq("rst_instr", instr, 32'h0);
        check_eq("rst_fault", 32'(fault), 32'd0);
        check_eq("rst_strobes", 32'({imem_req, dec_en, exec_en, rd_we, retire, rs1_read, rs2_read}), 32'd0);

        // Directed: minimum latency, operand timing, jump, wrap, stop at retire.
        do_instr(0, 0, 0, 0, 32'h0, 0, 0, 0, 1);
        do_instr(1, 1, 1, 0, 32'h0, 0, 1, 3, 1);
        do_instr(0, 0, 1, 1, 32'h40, 1, 0, 0, 1);
        do_instr(1, 0, 0, 1, 32'hFFFF_FFFC, 0, 2, 0, 1);
        do_instr(0, 1, 0, 0, 32'h0, 2, 0, 0, 0);
        check_eq("wrap_pc", pc, 32'h0);

        for (int i = 0; i < 40; i++) begin
            do_instr(1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2),
                     ($urandom % 3) == 0, $urandom & 32'hFFFF_FFFC,
                     $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                     1'($urandom % 2));
        end

        // Reset while waiting on an operand abandons the instruction.
        if (exp_idle) enter_fetch();
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0; dec_rs1_used = 1'b1; dec_rs2_used = 1'b1;
        tick();
        check_eq("mid_operand_state", 32'(state), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_pc = 32'h0; exp_instr = 32'h0; exp_idle = 1'b1;
        check_eq("midrst_state", 32'(state), 32'd0);
        check_eq("midrst_pc", pc, 32'h0);
        check_eq("midrst_reads", 32'({rs1_read, rs2_read}), 32'd0);
        check_eq("midrst_retire", 32'(retire), 32'd0);
        check_eq("midrst_instr", instr, 32'h0);

        // Two more instructions from IDLE, then a misaligned jump into HALT.
        do_instr(0, 0, 1, 0, 32'h0, 0, 0, 0, 0);
        do_instr(1, 0, 0, 0, 32'h0, 1, 0, 0, 0);
        do_instr(0, 0, 0, 1, 32'h42, 0, 0, 0, 1);
        run = 1'b1; step_req = 1'b1; imem_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("halt_hold", 32'(state), 32'd6);
            check_eq("halt_quiet", 32'({imem_req, dec_en, exec_en, rd_we, retire}), 32'd0);
            check_eq("halt_fault_sticky", 32'(fault), 32'd1);
            check_eq("halt_pc_hold", pc, exp_pc);
        end
        run = 1'b0; step_req = 1'b0; imem_ack = 1'b0;
        do_reset();
        check_eq("post_halt_rst_state", 32'(state), 32'd0);
        check_eq("post_halt_rst_fault", 32'(fault), 32'd0);
        tick();
        check_eq("retire_count", retire_seen, exp_retires);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
